// File: rtl/uart_rx_core.sv
// 8N1 UART receive engine: 16x oversampled start/data/stop capture, a
// valid/ready holding register and sticky framing/overrun flags.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              rx,
  input  logic              rx_en,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              rx_ready,
  input  logic              err_clr,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int          SYNC_STAGES = 2;
  localparam logic [3:0]  HALF_LAST   = 4'(SB_TICK / 2 - 1);
  localparam logic [3:0]  BIT_LAST    = 4'(SB_TICK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              s_cnt_reg, s_cnt_next;
  logic [2:0]              n_reg, n_next;
  logic [7:0]              shreg_reg, shreg_next;
  logic [DVSR_W-1:0]       tcnt_reg, tcnt_next;
  logic [SYNC_STAGES-1:0]  sync_reg;
  logic                    busy_reg;
  logic [7:0]              rx_data_reg;
  logic                    rx_valid_reg;
  logic                    frame_err_reg;
  logic                    overrun_reg;

  logic rx_s;
  logic tick;
  logic frame_done;
  logic frame_bad;
  logic load;
  logic drop;

  // Synchronizer flops idle high so reset never looks like a start bit.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];

  // >= rather than == so a divisor shrunk mid-frame cannot strand the counter.
  always_comb begin
    tick = 1'b0;
    if (dvsr <= DVSR_W'(1)) begin
      tick = 1'b1;
    end else if (tcnt_reg >= (dvsr - DVSR_W'(1))) begin
      tick = 1'b1;
    end
  end

  always_comb begin
    tcnt_next = tcnt_reg + DVSR_W'(1);
    if ((state_reg == IDLE) || !rx_en || tick) begin
      tcnt_next = '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tcnt_reg <= '0;
    end else begin
      tcnt_reg <= tcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_cnt_next = s_cnt_reg;
    n_next     = n_reg;
    shreg_next = shreg_reg;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    if (!rx_en) begin
      state_next = IDLE;
      s_cnt_next = 4'd0;
      n_next     = 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_next = START;
            s_cnt_next = 4'd0;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt_reg == HALF_LAST) begin
              if (!rx_s) begin
                state_next = DATA;
                s_cnt_next = 4'd0;
                n_next     = 3'd0;
              end else begin
                state_next = IDLE;
                s_cnt_next = 4'd0;
              end
            end else begin
              s_cnt_next = s_cnt_reg + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt_reg == BIT_LAST) begin
              shreg_next = {rx_s, shreg_reg[7:1]};
              s_cnt_next = 4'd0;
              if (n_reg == 3'd7) begin
                state_next = STOP;
              end else begin
                n_next = n_reg + 3'd1;
              end
            end else begin
              s_cnt_next = s_cnt_reg + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_cnt_reg == BIT_LAST) begin
              state_next = IDLE;
              s_cnt_next = 4'd0;
              frame_done = rx_s;
              frame_bad  = !rx_s;
            end else begin
              s_cnt_next = s_cnt_reg + 4'd1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          s_cnt_next = 4'd0;
          n_next     = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
      s_cnt_reg <= 4'd0;
      n_reg     <= 3'd0;
      shreg_reg <= 8'h00;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_cnt_reg <= s_cnt_next;
      n_reg     <= n_next;
      shreg_reg <= shreg_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  // A completed frame may refill the holding register in the same cycle it drains.
  assign load = frame_done && (!rx_valid_reg || rx_ready);
  assign drop = frame_done && rx_valid_reg && !rx_ready;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_data_reg  <= 8'h00;
      rx_valid_reg <= 1'b0;
    end else if (load) begin
      rx_data_reg  <= shreg_reg;
      rx_valid_reg <= 1'b1;
    end else if (rx_valid_reg && rx_ready) begin
      rx_valid_reg <= 1'b0;
    end
  end

  // Set has priority over clear so no error is lost to a racing err_clr.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (frame_bad) begin
        frame_err_reg <= 1'b1;
      end else if (err_clr) begin
        frame_err_reg <= 1'b0;
      end
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (err_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: a frame table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_uart_rx_core;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        rx_en;
  logic [15:0] dvsr;
  logic        rx_ready;
  logic        err_clr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int checks;
  int errors;
  logic [7:0] hs_q[$];

  uart_rx_core #(.SB_TICK(16), .DVSR_W(16)) dut (
    .PCLK     (clk),
    .PRESETn  (rst_n),
    .rx       (rx),
    .rx_en    (rx_en),
    .dvsr     (dvsr),
    .rx_ready (rx_ready),
    .err_clr  (err_clr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every accepted byte (valid && ready) for the streaming test.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) hs_q.push_back(rx_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        flush;
    logic [15:0] dv;
    logic [7:0]  data;
    logic        stop;
    logic [7:0]  exp_data;
    logic        exp_valid;
    logic        exp_fe;
    logic        exp_ov;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drives one 8N1 frame; max_cyc truncates it to leave a partial frame on the line.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_cyc,
                            input int max_cyc);
    logic [9:0] bits;
    int cnt;
    bits = {stop_bit, b, 1'b0};
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < bit_cyc; c++) begin
        if (cnt >= max_cyc) return;
        @(negedge clk);
        rx = bits[k];
        cnt++;
      end
    end
  endtask

  task automatic flush();
    @(negedge clk);
    rx_ready = 1'b1;
    err_clr  = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    check("flush_valid", {31'd0, rx_valid}, 32'd0);
    check("flush_frame_err", {31'd0, frame_err}, 32'd0);
    check("flush_overrun", {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    int bc;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_en    = 1'b1;
    dvsr     = 16'd4;
    rx_ready = 1'b0;
    err_clr  = 1'b0;

    vecs[0] = '{1'b1, 16'd4, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'd4, 8'h3C, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'd4, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'd4, 8'h22, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 16'd4, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'd4, 8'h3C, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'd4, 8'h66, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 16'd1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 16'd0, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 16'd3, 8'h81, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};

    idle(3);
    check("reset_data", {24'd0, rx_data}, 32'h00);
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].flush) flush();
      dvsr = vecs[v].dv;
      bc = 16 * ((vecs[v].dv <= 16'd1) ? 1 : int'(vecs[v].dv));
      send_frame(vecs[v].data, vecs[v].stop, bc, 10 * bc);
      @(negedge clk);
      rx = 1'b1;
      idle(120);
      $display("vec %0d: dvsr=%0d byte=0x%02h stop=%0d -> data=0x%02h valid=%0d fe=%0d ov=%0d",
               v, vecs[v].dv, vecs[v].data, vecs[v].stop, rx_data, rx_valid, frame_err, overrun);
      check("vec_data", {24'd0, rx_data}, {24'd0, vecs[v].exp_data});
      check("vec_valid", {31'd0, rx_valid}, {31'd0, vecs[v].exp_valid});
      check("vec_frame_err", {31'd0, frame_err}, {31'd0, vecs[v].exp_fe});
      check("vec_overrun", {31'd0, overrun}, {31'd0, vecs[v].exp_ov});
      check("vec_busy", {31'd0, busy}, 32'd0);
    end
    dvsr = 16'd4;

    // Single-cycle drain: valid drops the next cycle, data retained.
    flush();
    send_frame(8'hA5, 1'b1, 64, 640);
    idle(20);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    $display("drain: data=0x%02h valid=%0d", rx_data, rx_valid);
    check("drain_valid", {31'd0, rx_valid}, 32'd0);
    check("drain_data", {24'd0, rx_data}, 32'hA5);

    // Overrun then drain: overrun stays sticky.
    flush();
    send_frame(8'h11, 1'b1, 64, 640);
    send_frame(8'h22, 1'b1, 64, 640);
    idle(20);
    check("ovr_data", {24'd0, rx_data}, 32'h11);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    $display("overrun drain: valid=%0d ov=%0d", rx_valid, overrun);
    check("ovr_drain_valid", {31'd0, rx_valid}, 32'd0);
    check("ovr_still_set", {31'd0, overrun}, 32'd1);

    // Back-to-back frames with the consumer always ready.
    flush();
    hs_q.delete();
    rx_ready = 1'b1;
    send_frame(8'h00, 1'b1, 64, 640);
    send_frame(8'hFF, 1'b1, 64, 640);
    idle(40);
    rx_ready = 1'b0;
    $display("b2b: handshakes=%0d", hs_q.size());
    check("b2b_count", hs_q.size(), 32'd2);
    if (hs_q.size() == 2) begin
      check("b2b_first", {24'd0, hs_q[0]}, 32'h00);
      check("b2b_second", {24'd0, hs_q[1]}, 32'hFF);
    end
    check("b2b_frame_err", {31'd0, frame_err}, 32'd0);
    check("b2b_overrun", {31'd0, overrun}, 32'd0);

    // Glitch shorter than half a bit is rejected.
    flush();
    @(negedge clk);
    rx = 1'b0;
    idle(19);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rx = 1'b1;
    idle(60);
    $display("glitch: busy=%0d valid=%0d fe=%0d", busy, rx_valid, frame_err);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    check("glitch_frame_err", {31'd0, frame_err}, 32'd0);
    check("glitch_overrun", {31'd0, overrun}, 32'd0);

    // Abort during data bit 3, then receive cleanly after re-enable.
    send_frame(8'hC3, 1'b1, 64, 64 * 4 + 32);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rx_en = 1'b0;
    @(negedge clk);
    check("abort_busy_after", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    idle(10);
    rx_en = 1'b1;
    idle(10);
    check("abort_valid", {31'd0, rx_valid}, 32'd0);
    check("abort_frame_err", {31'd0, frame_err}, 32'd0);
    send_frame(8'h5A, 1'b1, 64, 640);
    idle(20);
    $display("after abort: data=0x%02h valid=%0d", rx_data, rx_valid);
    check("reen_data", {24'd0, rx_data}, 32'h5A);
    check("reen_valid", {31'd0, rx_valid}, 32'd1);
    check("reen_frame_err", {31'd0, frame_err}, 32'd0);

    // Asynchronous reset mid-frame with a byte held.
    send_frame(8'h99, 1'b1, 64, 200);
    #1;
    rst_n = 1'b0;
    #1;
    $display("async reset: data=0x%02h valid=%0d busy=%0d", rx_data, rx_valid, busy);
    check("areset_data", {24'd0, rx_data}, 32'h00);
    check("areset_valid", {31'd0, rx_valid}, 32'd0);
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_frame_err", {31'd0, frame_err}, 32'd0);
    check("areset_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
